rr_grant_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream datapath resource among N requesters.
- Emits a one-hot grant plus its binary index, which is the code the shared datapath consumes downstream.
- The grant is held until the owner releases it, then re-arbitration starts from the requester after the last owner.
- Sits between the requesting sub-units and the shared encode/datapath stage.

---
 rtl/rr_grant_arbiter_pkg.sv | 31 +++
 rtl/rr_grant_arbiter_pick.sv | 33 +++
 rtl/rr_grant_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_pkg
//   Shared types and helpers for the round-robin grant arbiter.
//   - state_t        : arbiter FSM state (IDLE / GRANT)
//   - N_DEF          : default number of requesters
//   - MAX_HOLD_DEF   : default forced-revoke hold limit
//   - onehot_to_idx  : one-hot (up to 16 bits) to binary, 0 for zero input
// ----------------------------------------------------------------------------
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEF        = 8;
    localparam int MAX_HOLD_DEF = 16;

    // OR-reduction encoder: correct for one-hot input, yields 0 for all-zero.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin winner selection.
//   Rotates req so that bit ptr lands at position 0, isolates the lowest set
//   bit, then rotates the one-hot back into requester order.
//   Ports:
//     req    [N-1:0]   request vector (already masked by the caller)
//     ptr    [IDW-1:0] highest-priority requester index (< N)
//     winner [N-1:0]   one-hot winner, zero when no request
//     found            high when any request bit is set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   winner,
    output logic           found
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_oh;

    always_comb begin
        // Doubling the vector turns the shift into a rotate.
        rot    = N'({req, req} >> ptr);
        rot_oh = rot & ((~rot) + N'(1));
        winner = N'(({rot_oh, rot_oh} << ptr) >> N);
        found  = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
//   Round-robin arbiter sharing one downstream datapath among N requesters.
//   A grant is held until its owner drops req; the next arbitration then
//   starts at the requester after the owner, with no idle bubble when another
//   request is waiting.
//
//   Optional feature (macro RR_GRANT_ARBITER_HOLD_TIMEOUT_EN): an owner that
//   has held the grant for MAX_HOLD cycles while someone else is waiting is
//   revoked, revoke pulses for one cycle and the grant moves on. Without the
//   macro there is no hold counter and revoke is tied low.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous active-high reset
//     en           arbitration enable (low: no new grants, current grant held)
//     req   [N]    request vector; dropping the owner's bit releases the grant
//     grant [N]    registered one-hot grant, zero when idle
//     grant_idx    registered binary index of the owner, 0 when idle
//     grant_valid  registered, equals |grant
//     revoke       one-cycle pulse on a forced revoke
//     state_dbg    current FSM state, for observation only
//
//   Handshake: a requester raises req[i] and keeps it high for the whole
//   transaction; it owns the resource in every cycle grant[i] is high, and
//   the cycle after it drops req[i] the grant is gone.
// ----------------------------------------------------------------------------
import rr_arb_pkg::*;

module rr_grant_arbiter #(
    parameter int N        = N_DEF,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           grant_valid,
    output logic           revoke,
    output state_t         state_dbg
);

    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_param_check
        $error("rr_grant_arbiter: N must be 2..16 and MAX_HOLD >= 1");
    end

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [N-1:0]   pick_req;
    logic [N-1:0]   winner;
    logic           found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] next_ptr;
    logic           owner_req;
    logic           load;
    logic           drop;
    logic           force_out;

    // ptr always equals (owner+1) mod N while granted, so masking the owner
    // out of req gives both the release and the revoke search for free.
    assign pick_req  = req & ~grant;
    assign owner_req = |(req & grant);
    assign state_dbg = state;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (pick_req),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    assign win_idx  = IDW'(onehot_to_idx(16'(winner)));
    assign next_ptr = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);

`ifdef RR_GRANT_ARBITER_HOLD_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hold_cnt;
    logic           hold_expired;

    assign hold_expired = (hold_cnt == HCW'(MAX_HOLD - 1));
    assign force_out    = (state == GRANT) && owner_req && hold_expired && en && found;
`else
    assign force_out    = 1'b0;
    assign revoke       = 1'b0;
`endif

    always_comb begin
        load = 1'b0;
        drop = 1'b0;
        case (state)
            IDLE: begin
                load = en && found;
            end
            GRANT: begin
                if (!owner_req) begin
                    load = en && found;
                    drop = !(en && found);
                end else begin
                    load = force_out;
                end
            end
            default: begin
                drop = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
`ifdef RR_GRANT_ARBITER_HOLD_TIMEOUT_EN
            hold_cnt    <= '0;
            revoke      <= 1'b0;
`endif
        end else begin
`ifdef RR_GRANT_ARBITER_HOLD_TIMEOUT_EN
            revoke <= force_out;
`endif
            if (load) begin
                state       <= GRANT;
                grant       <= winner;
                grant_idx   <= win_idx;
                grant_valid <= 1'b1;
                ptr         <= next_ptr;
`ifdef RR_GRANT_ARBITER_HOLD_TIMEOUT_EN
                hold_cnt    <= '0;
`endif
            end else if (drop) begin
                state       <= IDLE;
                grant       <= '0;
                grant_idx   <= '0;
                grant_valid <= 1'b0;
            end
`ifdef RR_GRANT_ARBITER_HOLD_TIMEOUT_EN
            else if (state == GRANT && !hold_expired) begin
                hold_cnt <= hold_cnt + HCW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
import rr_arb_pkg::*;

module tb_rr_grant_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int MH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [N-1:0] req = '0;

  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          revoke;
  state_t        state_dbg;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.N(N), .IDW(IW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
    .revoke(revoke), .state_dbg(state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // behavioural reference model: owner index (-1 = nobody), priority start,
  // number of cycles the current owner has held the grant
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_rev   = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_rev = 0;
    end else begin
      int w;
      m_rev = 0;
      if (m_owner < 0) begin
        w = pick(req, m_ptr);
        if (en && w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_held = 1; end
      end else if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        w = pick(req, m_ptr);
        if (en && w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_held = 1; end
        else m_owner = -1;
      end else begin
`ifdef RR_GRANT_ARBITER_HOLD_TIMEOUT_EN
        logic [N-1:0] others;
        others = req;
        others[m_owner] = 1'b0;
        w = pick(others, (m_owner + 1) % N);
        if (m_held >= MH && en && w >= 0) begin
          m_rev = 1; m_owner = w; m_ptr = (w + 1) % N; m_held = 1;
        end else m_held++;
`else
        m_held++;
`endif
      end
    end
  end

  // compare process: every falling edge outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant",  int'(grant),       (m_owner < 0) ? 0 : (1 << m_owner));
      chk("idx",    int'(grant_idx),   (m_owner < 0) ? 0 : m_owner);
      chk("valid",  int'(grant_valid), (m_owner < 0) ? 0 : 1);
      chk("revoke", int'(revoke),      int'(m_rev));
      chk("state",  int'(state_dbg == GRANT), (m_owner < 0) ? 0 : 1);
    end
  end

  // driver tasks
  task automatic do_reset(input logic [N-1:0] r, input logic e);
    rst = 1'b1; req = r; en = e;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // 1: single request, 1-cycle latency, held
    do_reset('0, 1'b1);
    chk("t1_reset_grant", int'(grant), 0);
    chk("t1_reset_valid", int'(grant_valid), 0);
    req = 8'b0000_0100;
    cyc();
    chk("t1_grant", int'(grant), 8'h04);
    chk("t1_idx", int'(grant_idx), 2);
    chk("t1_valid", int'(grant_valid), 1);
    req = 8'b0000_0110;
    repeat (3) begin
      cyc();
      chk("t1_hold", int'(grant_idx), 2);
    end

    // 2: all requesting, owners drop after 3 cycles, rotation with no bubble
    do_reset(8'hFF, 1'b1);
    for (int k = 0; k < 9; k++) begin
      cyc();
      req = 8'hFF;
      chk("t2_idx", int'(grant_idx), k % N);
      chk("t2_valid", int'(grant_valid), 1);
      cyc();
      cyc();
      req[k % N] = 1'b0;
    end

    // 3: wrap-around after owner 7
    do_reset(8'h80, 1'b1);
    cyc();
    chk("t3_idx7", int'(grant_idx), 7);
    req = 8'b0000_0011;
    cyc();
    chk("t3_idx0", int'(grant_idx), 0);
    req = 8'b0000_0010;
    cyc();
    chk("t3_idx1", int'(grant_idx), 1);

    // 4: enable gating
    do_reset(8'h10, 1'b0);
    repeat (5) begin
      cyc();
      chk("t4_disabled", int'(grant), 0);
    end
    en = 1'b1;
    cyc();
    chk("t4_enabled", int'(grant), 8'h10);
    en = 1'b0;
    req = 8'h11;
    repeat (3) begin
      cyc();
      chk("t4_held", int'(grant), 8'h10);
    end
    req = 8'h01;
    cyc();
    chk("t4_release_en0", int'(grant), 0);

    // 5: asynchronous reset mid-grant, pointer back to 0
    do_reset(8'h20, 1'b1);
    cyc();
    chk("t5_idx5", int'(grant_idx), 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_grant", int'(grant), 0);
    chk("t5_async_idx", int'(grant_idx), 0);
    chk("t5_async_valid", int'(grant_valid), 0);
    cyc();
    req = 8'h21;
    rst = 1'b0;
    cyc();
    chk("t5_ptr0", int'(grant_idx), 0);

    // 6: hold timeout
    do_reset(8'h08, 1'b1);
    cyc();
    chk("t6_idx3", int'(grant_idx), 3);
    req = 8'h48;
    repeat (3) begin
      cyc();
      chk("t6_still3", int'(grant_idx), 3);
      chk("t6_no_rev", int'(revoke), 0);
    end
    cyc();
`ifdef RR_GRANT_ARBITER_HOLD_TIMEOUT_EN
    chk("t6_rev_idx", int'(grant_idx), 6);
    chk("t6_rev_pulse", int'(revoke), 1);
    cyc();
    chk("t6_rev_low", int'(revoke), 0);
    chk("t6_idx6", int'(grant_idx), 6);
`else
    repeat (4) begin
      chk("t6_keep3", int'(grant_idx), 3);
      chk("t6_rev0", int'(revoke), 0);
      cyc();
    end
`endif

    // random phase: sticky requests, occasional en drop and async reset
    do_reset('0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rnd_async_grant", int'(grant), 0);
        cyc();
        rst = 1'b0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
